// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin packet arbiter.
package rr_arb_pkg;

  // Arbiter control state: free to arbitrate, or holding a packet owner.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width of each per-port starvation wait counter (saturates at all ones).
  localparam int CNT_W = 8;

endpackage

// File: rtl/fixed_prio_arb.sv
// Combinational fixed-priority arbiter: lowest set request bit wins, one-hot grant.
module fixed_prio_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  logic found;

  // Scan upward from port 0 and grant the first requester found.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: grants one requester per packet and holds the
// grant until the last beat is accepted, then rotates priority past the winner.
// Optional per-port starvation flags are built when RR_ARB_STARVE_EN is defined;
// otherwise starve_o is tied low and no counters exist.
module rr_packet_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N            = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         last_i,
  input  logic                 ready_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic [N-1:0]         starve_o
);

  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic [IDX_W-1:0] win, win_next;
  logic [N-1:0]     mask;
  logic [N-1:0]     gnt_masked, gnt_unmasked, arb_gnt;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             xfer;

  // Rotating priority pointer advance, wrapping from the top port back to 0.
  function automatic logic [IDX_W-1:0] after(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Keep only requesters at or above the priority pointer.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IDX_W'(i) >= ptr);
    end
  end

  fixed_prio_arb #(.N(N)) u_masked_arb (
    .req (req_i & mask),
    .gnt (gnt_masked)
  );

  fixed_prio_arb #(.N(N)) u_unmasked_arb (
    .req (req_i),
    .gnt (gnt_unmasked)
  );

  // Upper-half winner takes precedence; otherwise the search wraps to port 0.
  assign arb_gnt = (|gnt_masked) ? gnt_masked : gnt_unmasked;

  // Grant is the live arbitration result when idle, the held owner when locked,
  // and forced to zero while reset is asserted.
  always_comb begin
    gnt = '0;
    if (reset) begin
      if (state == LOCKED) begin
        gnt[win] = 1'b1;
      end else begin
        gnt = arb_gnt;
      end
    end
  end

  // Binary index of the (one-hot) grant; zero when nothing is granted.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign valid_o   = |(gnt & req_i);
  assign xfer      = valid_o & ready_i;
  assign gnt_o     = gnt;
  assign gnt_idx_o = gnt_idx;
  assign busy_o    = (state == LOCKED);

  // Next-state logic: lock onto a winner unless its single-beat packet
  // completes immediately; release and rotate on the last accepted beat.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    win_next   = win;
    case (state)
      IDLE: begin
        if (|gnt) begin
          if (xfer && last_i[gnt_idx]) begin
            ptr_next = after(gnt_idx);
          end else begin
            win_next   = gnt_idx;
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (xfer && last_i[win]) begin
          ptr_next   = after(win);
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, pointer and held-winner registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      win   <= win_next;
    end
  end

  // A limit outside the counter range could never be reached; such a build
  // shows up as this named block in the elaborated hierarchy.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (2**CNT_W) - 1) begin : g_starve_limit_out_of_range
  end

`ifdef RR_ARB_STARVE_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] wait_cnt [N];

  // Count cycles each port spends requesting without a grant, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_i[i] && !gnt[i]) begin
          if (wait_cnt[i] != '1) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
    end
  end

  // Flag every port whose wait has reached the limit.
  always_comb begin
    starve_o = '0;
    for (int i = 0; i < N; i++) begin
      starve_o[i] = (wait_cnt[i] >= LIMIT);
    end
  end
`else
  assign starve_o = '0;
`endif

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench for rr_packet_arbiter: a driver issues directed scenarios
// and random traffic, a packet-level reference model queues the expected
// per-cycle response, and a monitor compares it against the DUT outputs.
// Starvation expectations follow RR_ARB_STARVE_EN when it is defined.
module tb_rr_packet_arbiter;

  localparam int N     = 4;
  localparam int IDX_W = 2;
  localparam int LIMIT = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_i = '0;
  logic [N-1:0]     last_i = '0;
  logic             ready_i = 1'b0;
  logic [N-1:0]     gnt_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic             valid_o;
  logic             busy_o;
  logic [N-1:0]     starve_o;

  rr_packet_arbiter #(.N(N), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_i),
    .last_i    (last_i),
    .ready_i   (ready_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o),
    .starve_o  (starve_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             busy;
    logic [N-1:0]     starve;
  } resp_t;

  resp_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model state: who owns the current packet, where the next
  // round-robin search begins, and how long each port has been kept waiting.
  int m_next   = 0;
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_wait[N];

  // Drive one cycle of inputs, queue the expected response, advance the model.
  task automatic apply_stimulus(input logic rst, input logic [N-1:0] rq,
                                input logic [N-1:0] lst, input logic rdy);
    resp_t e;
    int    owner;
    bit    accepted;
    @(posedge clk);
    #1;
    reset   = rst;
    req_i   = rq;
    last_i  = lst;
    ready_i = rdy;
    e     = '0;
    owner = -1;
    if (!rst) begin
      m_next   = 0;
      m_locked = 1'b0;
      m_owner  = 0;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      exp_q.push_back(e);
    end else begin
      if (m_locked) begin
        owner = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (owner < 0 && rq[(m_next + k) % N]) owner = (m_next + k) % N;
        end
      end
      if (owner >= 0) begin
        e.gnt   = N'(1) << owner;
        e.idx   = IDX_W'(owner);
        e.valid = rq[owner];
      end
      e.busy = m_locked;
`ifdef RR_ARB_STARVE_EN
      for (int i = 0; i < N; i++) e.starve[i] = (m_wait[i] >= LIMIT);
`endif
      exp_q.push_back(e);
      for (int i = 0; i < N; i++) begin
        if (rq[i] && owner != i) begin
          if (m_wait[i] < 255) m_wait[i] = m_wait[i] + 1;
        end else begin
          m_wait[i] = 0;
        end
      end
      accepted = e.valid && rdy;
      if (owner >= 0) begin
        if (accepted && lst[owner]) begin
          m_locked = 1'b0;
          m_next   = (owner + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner  = owner;
        end
      end
    end
  endtask

  // Compare one observed response against the queued expectation.
  task automatic check_output(input resp_t e);
    resp_t a;
    a = {gnt_o, gnt_idx_o, valid_o, busy_o, starve_o};
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL resp @%0t: got gnt=%b idx=%0d valid=%b busy=%b starve=%b, expected gnt=%b idx=%0d valid=%b busy=%b starve=%b",
               $time, a.gnt, a.idx, a.valid, a.busy, a.starve,
               e.gnt, e.idx, e.valid, e.busy, e.starve);
    end
  endtask

  // Monitor: sample mid-cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) m_wait[i] = 0;

    // Reset held with all requesting, then rotation with single-beat packets.
    repeat (3) apply_stimulus(1'b0, 4'hF, 4'h0, 1'b1);
    repeat (5) apply_stimulus(1'b1, 4'hF, 4'hF, 1'b1);

    // Lock: port 0 sends a four-beat packet while port 1 waits.
    apply_stimulus(1'b0, 4'h0, 4'h0, 1'b1);
    repeat (3) apply_stimulus(1'b1, 4'h3, 4'h0, 1'b1);
    apply_stimulus(1'b1, 4'h3, 4'h1, 1'b1);
    apply_stimulus(1'b1, 4'h2, 4'h2, 1'b1);

    // Backpressure: port 2 stalled, port 0 joins, then port 2 completes.
    apply_stimulus(1'b1, 4'h4, 4'h0, 1'b0);
    repeat (4) apply_stimulus(1'b1, 4'h5, 4'h0, 1'b0);
    apply_stimulus(1'b1, 4'h5, 4'h4, 1'b1);
    apply_stimulus(1'b1, 4'h1, 4'h1, 1'b1);

    // Dropped request inside a lock, then reset mid-lock.
    apply_stimulus(1'b1, 4'h2, 4'h0, 1'b0);
    apply_stimulus(1'b1, 4'h0, 4'h0, 1'b1);
    apply_stimulus(1'b1, 4'h2, 4'h0, 1'b1);
    apply_stimulus(1'b0, 4'h2, 4'h0, 1'b1);
    apply_stimulus(1'b1, 4'h6, 4'h0, 1'b1);
    apply_stimulus(1'b1, 4'h6, 4'h2, 1'b1);
    apply_stimulus(1'b1, 4'h4, 4'h4, 1'b1);

    // Starvation: port 0 holds a six-beat packet while port 3 waits.
    apply_stimulus(1'b0, 4'h0, 4'h0, 1'b1);
    repeat (5) apply_stimulus(1'b1, 4'h9, 4'h0, 1'b1);
    apply_stimulus(1'b1, 4'h9, 4'h1, 1'b1);
    apply_stimulus(1'b1, 4'h8, 4'h8, 1'b1);
    repeat (2) apply_stimulus(1'b1, 4'h0, 4'h0, 1'b1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      apply_stimulus($urandom_range(0, 63) != 0, N'($urandom), N'($urandom),
                     $urandom_range(0, 3) != 0);
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d responses left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
